// File: rtl/alu_pkg.sv
// Shared definitions for the registered 8-bit ALU and its sequencer/arbiter.
// Opcode values mirror the ALU's alu_control decode.
package alu_pkg;

  localparam int ALU_DW  = 8;
  localparam int ALU_OPW = 4;

  localparam logic [ALU_OPW-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALU_OPW-1:0] ALU_SUB = 4'b0001;
  localparam logic [ALU_OPW-1:0] ALU_AND = 4'b0010;
  localparam logic [ALU_OPW-1:0] ALU_NOR = 4'b0011;
  localparam logic [ALU_OPW-1:0] ALU_SHL = 4'b1100;
  localparam logic [ALU_OPW-1:0] ALU_SHR = 4'b1101;
  localparam logic [ALU_OPW-1:0] ALU_LT  = 4'b1011;
  localparam logic [ALU_OPW-1:0] ALU_NE  = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CAPT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: one-hot grant, pointer breaks ties.
// Purely combinational; the pointer register lives in the caller.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Sequencer and round-robin arbiter in front of a shared registered ALU.
// Accepts one request, drives the ALU operand registers, captures acc and returns it.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int DW   = ALU_DW,
  parameter int OPW  = ALU_OPW,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2*DW-1:0]   req_c,
  input  logic [2*DW-1:0]   req_d,
  input  logic [2*OPW-1:0]  req_op,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DW-1:0]     rsp_data,
  output logic [DW-1:0]     alu_c,
  output logic [DW-1:0]     alu_d,
  output logic [OPW-1:0]    alu_op,
  input  logic [DW-1:0]     alu_acc,
  output logic              busy,
  output logic [CNTW-1:0]   ops_done
);

  state_t           state_q, state_d;
  logic             grant_q, grant_d;
  logic             ptr_q, ptr_d;
  logic [DW-1:0]    alu_c_q, alu_c_d;
  logic [DW-1:0]    alu_d_q, alu_d_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic [DW-1:0]    rsp_data_q, rsp_data_d;
  logic [CNTW-1:0]  ops_done_q, ops_done_d;
  logic [1:0]       arb_gnt;

  rr_arb2 u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (arb_gnt)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    alu_c_d    = alu_c_q;
    alu_d_d    = alu_d_q;
    alu_op_d   = alu_op_q;
    rsp_data_d = rsp_data_q;
    ops_done_d = ops_done_q;
    req_ready  = 2'b00;
    rsp_valid  = 2'b00;

    unique case (state_q)
      ST_IDLE: begin
        req_ready = arb_gnt;
        if (arb_gnt != 2'b00) begin
          grant_d  = arb_gnt[1];
          alu_c_d  = arb_gnt[1] ? req_c[DW +: DW]   : req_c[0 +: DW];
          alu_d_d  = arb_gnt[1] ? req_d[DW +: DW]   : req_d[0 +: DW];
          alu_op_d = arb_gnt[1] ? req_op[OPW +: OPW] : req_op[0 +: OPW];
          state_d  = ST_EXEC;
        end
      end
      // The ALU samples alu_* on the edge that ends EXEC; acc is valid during CAPT.
      ST_EXEC: state_d = ST_CAPT;
      ST_CAPT: begin
        rsp_data_d = alu_acc;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid[grant_q] = 1'b1;
        if (rsp_ready[grant_q]) begin
          ptr_d   = ~grant_q;
          state_d = ST_IDLE;
          if (ops_done_q != {CNTW{1'b1}}) ops_done_d = ops_done_q + CNTW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= 1'b0;
      ptr_q      <= 1'b0;
      alu_c_q    <= '0;
      alu_d_q    <= '0;
      alu_op_q   <= '0;
      rsp_data_q <= '0;
      ops_done_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      alu_c_q    <= alu_c_d;
      alu_d_q    <= alu_d_d;
      alu_op_q   <= alu_op_d;
      rsp_data_q <= rsp_data_d;
      ops_done_q <= ops_done_d;
    end
  end

  assign alu_c    = alu_c_q;
  assign alu_d    = alu_d_q;
  assign alu_op   = alu_op_q;
  assign rsp_data = rsp_data_q;
  assign ops_done = ops_done_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural registered ALU and
// a result scoreboard; counter width reduced so saturation is reachable.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  localparam int DW   = 8;
  localparam int OPW  = 4;
  localparam int CNTW = 3;

  logic              clk;
  logic              reset;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [2*DW-1:0]   req_c;
  logic [2*DW-1:0]   req_d;
  logic [2*OPW-1:0]  req_op;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [DW-1:0]     rsp_data;
  logic [DW-1:0]     alu_c;
  logic [DW-1:0]     alu_d;
  logic [OPW-1:0]    alu_op;
  logic [DW-1:0]     alu_acc;
  logic              busy;
  logic [CNTW-1:0]   ops_done;

  int checks   = 0;
  int failures = 0;
  int exp_ops  = 0;
  logic [DW-1:0] sb[$];

  alu_share_ctrl #(.DW(DW), .OPW(OPW), .CNTW(CNTW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_c     (req_c),
    .req_d     (req_d),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .alu_c     (alu_c),
    .alu_d     (alu_d),
    .alu_op    (alu_op),
    .alu_acc   (alu_acc),
    .busy      (busy),
    .ops_done  (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] c, input logic [DW-1:0] d,
                                          input logic [OPW-1:0] op);
    case (op)
      ALU_SUB: return d - c;
      ALU_AND: return c & d;
      ALU_NOR: return ~(c | d);
      ALU_SHL: return d << c;
      ALU_SHR: return d >> c;
      ALU_LT:  return {{(DW-1){1'b0}}, (d < c)};
      ALU_NE:  return {{(DW-1){1'b0}}, (d != c)};
      default: return c + d;
    endcase
  endfunction

  // Behavioural model of the shared ALU: acc registered on the rising edge.
  initial alu_acc = '0;
  always @(posedge clk) alu_acc <= alu_f(alu_c, alu_d, alu_op);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int i, input logic [DW-1:0] c, input logic [DW-1:0] d,
                           input logic [OPW-1:0] op);
    req_c[i*DW +: DW]    = c;
    req_d[i*DW +: DW]    = d;
    req_op[i*OPW +: OPW] = op;
    req_valid[i]         = 1'b1;
  endtask

  function automatic void bump_ops();
    if (exp_ops < (1 << CNTW) - 1) exp_ops++;
  endfunction

  // Waits (bounded) for requester i to be granted, then completes the accept edge.
  task automatic accept(input int i, input logic [DW-1:0] exp);
    int n = 0;
    #1;
    while (!req_ready[i] && n < 20) begin
      tick();
      n++;
    end
    check("req_ready_grant", 32'(req_ready), 32'd1 << i);
    sb.push_back(exp);
    tick();
    req_valid[i] = 1'b0;
  endtask

  // Waits (bounded) for a response to i, holds it off for 'hold' cycles, then consumes it.
  task automatic respond(input int i, input int hold);
    int n = 0;
    logic [DW-1:0] e;
    while (!rsp_valid[i] && n < 20) begin
      tick();
      n++;
    end
    e = (sb.size() != 0) ? sb.pop_front() : 'x;
    check("rsp_valid", 32'(rsp_valid), 32'd1 << i);
    check("rsp_data", 32'(rsp_data), 32'(e));
    for (int k = 0; k < hold; k++) begin
      tick();
      check("rsp_valid_held", 32'(rsp_valid), 32'd1 << i);
      check("rsp_data_held", 32'(rsp_data), 32'(e));
      check("req_ready_while_resp", 32'(req_ready), 32'd0);
    end
    rsp_ready[i] = 1'b1;
    tick();
    rsp_ready[i] = 1'b0;
    bump_ops();
    check("rsp_valid_cleared", 32'(rsp_valid), 32'd0);
    check("ops_done", 32'(ops_done), 32'(exp_ops));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] rc, rd;
    logic [OPW-1:0] rop;
    logic [OPW-1:0] op_tab [6];
    int n;

    op_tab[0] = ALU_ADD; op_tab[1] = ALU_SUB; op_tab[2] = ALU_AND;
    op_tab[3] = ALU_SHR; op_tab[4] = ALU_LT;  op_tab[5] = ALU_NOR;

    reset     = 1'b1;
    req_valid = '0;
    req_c     = '0;
    req_d     = '0;
    req_op    = '0;
    rsp_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_alu_op", 32'(alu_op), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_ops_done", 32'(ops_done), 32'd0);
    reset = 1'b0;
    tick();

    // Single add on requester 0 with explicit latency checks.
    drive_req(0, 8'd3, 8'd5, ALU_ADD);
    #1;
    check("t1_req_ready", 32'(req_ready), 32'b01);
    sb.push_back(8'd8);
    tick();
    req_valid[0] = 1'b0;
    #1;
    check("t1_req_ready_one_cycle", 32'(req_ready), 32'd0);
    check("t1_alu_op", 32'(alu_op), 32'(ALU_ADD));
    check("t1_alu_c", 32'(alu_c), 32'd3);
    check("t1_alu_d", 32'(alu_d), 32'd5);
    check("t1_busy", 32'(busy), 32'd1);
    tick();
    check("t1_rsp_not_yet", 32'(rsp_valid), 32'd0);
    tick();
    check("t1_rsp_after_3_edges", 32'(rsp_valid), 32'b01);
    respond(0, 0);

    // Both requesters together from a fresh pointer: req0, req1, then req0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_ops = 0;
    sb.delete();
    tick();
    drive_req(0, 8'd3, 8'd5, ALU_SUB);
    drive_req(1, 8'hF0, 8'h0F, ALU_NOR);
    accept(0, 8'd2);
    respond(0, 0);
    drive_req(0, 8'd1, 8'd1, ALU_ADD);
    accept(1, 8'h00);
    check("t2_req0_waits", 32'(req_valid[0]), 32'd1);
    respond(1, 0);
    accept(0, 8'd2);
    respond(0, 0);

    // Backpressure on requester 1 with requester 0 pending.
    drive_req(1, 8'd3, 8'h01, ALU_SHL);
    accept(1, 8'h08);
    drive_req(0, 8'hF0, 8'h3C, ALU_AND);
    respond(1, 5);
    accept(0, 8'h30);
    respond(0, 0);

    // Reset during EXEC drops the operation and resets the pointer.
    drive_req(0, 8'd7, 8'd2, ALU_LT);
    accept(0, 8'd1);
    check("t4_in_exec", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("t4_rst_alu_c", 32'(alu_c), 32'd0);
    check("t4_rst_alu_d", 32'(alu_d), 32'd0);
    check("t4_rst_alu_op", 32'(alu_op), 32'd0);
    check("t4_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t4_rst_rsp_data", 32'(rsp_data), 32'd0);
    check("t4_rst_busy", 32'(busy), 32'd0);
    check("t4_rst_ops_done", 32'(ops_done), 32'd0);
    sb.delete();
    exp_ops = 0;
    tick();
    reset = 1'b0;
    repeat (4) tick();
    check("t4_no_rsp_after_reset", 32'(rsp_valid), 32'd0);
    drive_req(0, 8'h10, 8'h20, ALU_ADD);
    drive_req(1, 8'h40, 8'h02, ALU_ADD);
    accept(0, 8'h30);
    respond(0, 0);
    accept(1, 8'h42);
    respond(1, 0);

    // rsp_ready on the wrong port is ignored.
    drive_req(0, 8'd4, 8'd4, ALU_NE);
    accept(0, 8'd0);
    n = 0;
    while (!rsp_valid[0] && n < 20) begin
      tick();
      n++;
    end
    rsp_ready[1] = 1'b1;
    tick();
    rsp_ready[1] = 1'b0;
    check("t5_rsp_valid_kept", 32'(rsp_valid), 32'b01);
    check("t5_busy_kept", 32'(busy), 32'd1);
    check("t5_ops_unchanged", 32'(ops_done), 32'(exp_ops));
    respond(0, 0);

    // Run past the reduced counter's maximum.
    for (int k = 0; k < 6; k++) begin
      rc  = 8'($urandom_range(0, 7));
      rd  = 8'($urandom_range(0, 255));
      rop = op_tab[k];
      drive_req(k % 2, rc, rd, rop);
      accept(k % 2, alu_f(rc, rd, rop));
      respond(k % 2, k % 3);
    end
    check("t6_ops_saturated", 32'(ops_done), 32'((1 << CNTW) - 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
Sequencer and two-way arbiter for the shared registered 8-bit ALU (operands c/d, 4-bit alu_control, result acc registered on posedge clk).
- Two requesters (e.g. the execute stage and a debug/test port) issue operations over valid/ready handshakes.
- The block grants one requester round-robin, drives the ALU operand/opcode registers, waits out the ALU's one-edge latency, captures acc and returns it on a per-requester response handshake.

Parameters:
DW, 8, operand/result width (must match ALU).
OPW, 4, opcode width (must match alu_control).
CNTW, 16, width of saturating completed-operation counter.

Ports:
clk  in  1  system clock, all state on rising edge.
reset  in  1  asynchronous, active-high reset.
req_valid  in  2  request valid per requester (bit i = requester i).
req_ready  out  2  request accepted this cycle, one-hot or zero.
req_c  in  2*DW  c operands, requester i at [i*DW +: DW].
req_d  in  2*DW  d operands, same packing.
req_op  in  2*OPW  opcodes, requester i at [i*OPW +: OPW].
rsp_valid  out  2  result valid for requester i, one-hot or zero.
rsp_ready  in  2  requester i consumes result.
rsp_data  out  DW  result, valid while any rsp_valid bit is high.
alu_c  out  DW  registered operand c to ALU.
alu_d  out  DW  registered operand d to ALU.
alu_op  out  OPW  registered alu_control to ALU.
alu_acc  in  DW  ALU acc output.
busy  out  1  high in any state other than IDLE.
ops_done  out  CNTW  saturating count of completed responses.

Behaviour:
- Reset (async, active-high): state=IDLE; alu_c/alu_d/alu_op=0; rsp_data=0; req_ready=0; rsp_valid=0; ops_done=0; grant register=0; priority pointer=0 (requester 0 favoured).
- FSM states and transitions:
  - IDLE: req_ready is combinational, asserted only for the granted requester. If exactly one req_valid is high, grant it. If both are high, grant the pointer's requester. On that edge, latch the granted requester's c/d/op into alu_c/alu_d/alu_op, store the grant, and go to EXEC. With no req_valid, stay in IDLE and hold the alu_* registers.
  - EXEC: one cycle. The ALU samples alu_* at the ending edge. Go to CAPT.
  - CAPT: one cycle. Latch alu_acc into rsp_data. Go to RESP.
  - RESP: rsp_valid[grant]=1, rsp_data stable. On rsp_ready[grant]=1: clear rsp_valid, set pointer = ~grant, increment ops_done (hold at all-ones), go to IDLE. rsp_ready on the non-granted bit is ignored.
- Latency: accept edge to rsp_valid high is 3 edges. Minimum issue interval is 4 cycles per operation; no new request is accepted before RESP completes.
- Opcodes pass through unmodified; no decoding. The ALU defines add(0000), sub d-c(0001), and(0010), nor(0011), shl(1100), shr(1101), lt(1011), ne(1010), and treats all others as add.
- alu_* registers hold their last values outside IDLE-accept edges, so the ALU keeps recomputing the same result.
- Handshake rules:
  - A requester must hold req_* stable while req_valid is high and not yet accepted.
  - Deasserting req_valid before acceptance is legal and leaves no side effect.
- Simultaneous events:
  - Both requesters request together: grants alternate.
  - A new req_valid arriving during EXEC/CAPT/RESP waits, with req_ready=0.
- Reset mid-operation drops the in-flight operation: no response, and the pointer returns to 0.
- ops_done saturates at 2^CNTW-1 and does not wrap.

Decomposition:
Shared package alu_pkg holds:
- ALU opcode constants: ALU_ADD=4'b0000, ALU_SUB=4'b0001, ALU_AND=4'b0010, ALU_NOR=4'b0011, ALU_SHL=4'b1100, ALU_SHR=4'b1101, ALU_LT=4'b1011, ALU_NE=4'b1010.
- FSM state encoding: IDLE, EXEC, CAPT, RESP.
- DW/OPW defaults.

Sub-module rr_arb2 is a 2-input round-robin arbiter (req[1:0], pointer → one-hot grant), combinational. The FSM and datapath registers stay in alu_share_ctrl.

Test Plan:
- Reset, then req0 add with c=3, d=5: req_ready[0] high 1 cycle; alu_op=0000 next cycle; rsp_valid[0] 3 edges after accept; rsp_data=8; ops_done=1.
- Both requesters valid together: req0 sub (d=5, c=3) and req1 nor (d=8'h0F, c=8'hF0). Grant order is req0 then req1. Responses are 2 then 8'h00. Back-to-back, req0 is granted again only after req1.
- Response backpressure: req1 shl with d=8'h01, c=3, rsp_ready[1] held low for 5 cycles. rsp_valid[1] and rsp_data=8'h08 stay stable. A pending req0 sees req_ready=0 until the handshake.
- Assert reset during EXEC of req0 lt (d=2, c=7): all outputs return to 0 immediately, no rsp_valid, ops_done unchanged at 0. The next request is served normally.
- Wrong-port ready: during RESP for req0 (ne, d=4, c=4 → 0), pulse rsp_ready[1]. rsp_valid[0] stays high, and the state does not advance.
- Force ops_done to all-ones via 2^16 completions (or a reduced CNTW=3 build running 9 ops): counter holds at max.
